// File: rtl/aes_128_pkg.sv
// Shared AES-128 definitions: FSM state encoding, byte geometry and byte/ShiftRows helpers.
package aes_128_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam int NUM_BYTES         = 16;
    localparam int LOOKUPS_PER_CYCLE = 2;
    localparam int ISSUE_CYCLES      = NUM_BYTES / LOOKUPS_PER_CYCLE;

    // Byte i sits at bits [127-8i -: 8]; {~i, 3'b000} is that slice's low bit.
    function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] i);
        return s[{~i, 3'b000} +: 8];
    endfunction

    // Column-major ShiftRows: output byte 4c+r takes input byte 4((c+r) mod 4)+r.
    function automatic int unsigned shift_rows_idx(input int unsigned i);
        int unsigned c;
        int unsigned r;
        c = i / 4;
        r = i % 4;
        return 4 * ((c + r) % 4) + r;
    endfunction

endpackage

// File: rtl/aes_128_sub_bytes_ctrl_if.sv
// Request/response bundle between the round datapath (master) and the SubBytes controller (slave).
interface aes_128_sub_bytes_ctrl_if;
    logic         start;
    logic         abort;
    logic [127:0] data_in;
    logic         busy;
    logic         done;
    logic [127:0] data_out;

    modport master (output start, abort, data_in, input busy, done, data_out);
    modport slave  (input start, abort, data_in, output busy, done, data_out);
endinterface

// File: rtl/aes_128_sbox_capture.sv
// Tracks in-flight S-box lookups and collects the returned bytes into a 16-entry result file.
module aes_128_sbox_capture
    import aes_128_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic       clk,
    input  logic       kill_n,
    input  logic       flush,
    input  logic       issue,
    input  logic [2:0] issue_idx,
    input  logic [7:0] sbox_doa,
    input  logic [7:0] sbox_dob,
    output logic       capture_last,
    output logic [7:0] result_next [NUM_BYTES]
);
    logic [SBOX_LAT-1:0] pipe_valid;
    logic [2:0]          pipe_idx [SBOX_LAT];
    logic [7:0]          result [NUM_BYTES];
    logic                capture;
    logic [2:0]          cap_idx;

    assign capture      = pipe_valid[SBOX_LAT-1];
    assign cap_idx      = pipe_idx[SBOX_LAT-1];
    assign capture_last = capture && (cap_idx == 3'(ISSUE_CYCLES - 1));

    // The tail of this pipe lines up with the cycle the S-box presents data for that issue.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            pipe_valid <= '0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                pipe_idx[i] <= '0;
            end
        end else if (flush) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= issue;
            pipe_idx[0]   <= issue_idx;
            for (int i = 1; i < SBOX_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_idx[i]   <= pipe_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                result[i] <= '0;
            end
        end else if (capture) begin
            result[{cap_idx, 1'b0}] <= sbox_doa;
            result[{cap_idx, 1'b1}] <= sbox_dob;
        end
    end

    // Forward the capture in flight so the final pair reaches the output register without a bubble.
    always_comb begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            result_next[i] = result[i];
        end
        if (capture) begin
            result_next[{cap_idx, 1'b0}] = sbox_doa;
            result_next[{cap_idx, 1'b1}] = sbox_dob;
        end
    end

endmodule

// File: rtl/aes_128_sub_bytes_ctrl.sv
// SubBytes controller: streams one 128-bit state through a dual-port S-box, two bytes per cycle.
// Define AES_SUB_BYTES_SHIFTROWS_EN to apply ShiftRows at the output register.
module aes_128_sub_bytes_ctrl
    import aes_128_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic                    clk,
    input  logic                    kill_n,
    aes_128_sub_bytes_ctrl_if.slave bus,
    output logic [7:0]              sbox_addra,
    output logic [7:0]              sbox_addrb,
    output logic                    sbox_kill,
    input  logic [7:0]              sbox_doa,
    input  logic [7:0]              sbox_dob
);
    state_t       state;
    logic [2:0]   issue_k;
    logic [2:0]   next_k;
    logic [127:0] latched;
    logic [127:0] data_out_q;
    logic [127:0] result_word;
    logic [7:0]   sub_bytes [NUM_BYTES];
    logic         capture_last;
    logic         issuing;

    assign issuing = (state == ISSUE);
    assign next_k  = issue_k + 3'd1;

    aes_128_sbox_capture #(.SBOX_LAT(SBOX_LAT)) u_capture (
        .clk          (clk),
        .kill_n       (kill_n),
        .flush        (bus.abort),
        .issue        (issuing),
        .issue_idx    (issue_k),
        .sbox_doa     (sbox_doa),
        .sbox_dob     (sbox_dob),
        .capture_last (capture_last),
        .result_next  (sub_bytes)
    );

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_out
`ifdef AES_SUB_BYTES_SHIFTROWS_EN
        localparam int SRC = shift_rows_idx(i);
        assign result_word[127-8*i -: 8] = sub_bytes[SRC];
`else
        assign result_word[127-8*i -: 8] = sub_bytes[i];
`endif
    end

    // Addresses are registered so they hold outside ISSUE; abort overrides every state.
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state      <= IDLE;
            issue_k    <= '0;
            latched    <= '0;
            sbox_addra <= '0;
            sbox_addrb <= '0;
            sbox_kill  <= 1'b1;
            data_out_q <= '0;
        end else begin
            sbox_kill <= bus.abort;
            if (bus.abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state      <= ISSUE;
                            issue_k    <= '0;
                            latched    <= bus.data_in;
                            sbox_addra <= get_byte(bus.data_in, 4'd0);
                            sbox_addrb <= get_byte(bus.data_in, 4'd1);
                        end
                    end
                    ISSUE: begin
                        if (issue_k == 3'(ISSUE_CYCLES - 1)) begin
                            state <= DRAIN;
                        end else begin
                            issue_k    <= next_k;
                            sbox_addra <= get_byte(latched, {next_k, 1'b0});
                            sbox_addrb <= get_byte(latched, {next_k, 1'b1});
                        end
                    end
                    DRAIN: begin
                        if (capture_last) begin
                            state      <= DONE;
                            data_out_q <= result_word;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy     = (state == ISSUE) || (state == DRAIN);
    assign bus.done     = (state == DONE);
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_aes_128_sub_bytes_ctrl.sv
// Bench for aes_128_sub_bytes_ctrl: cycle-level reference model plus directed FIPS-197 vectors.
// Honours AES_SUB_BYTES_SHIFTROWS_EN in the same way as the design.
module tb_aes_128_sub_bytes_ctrl;

    localparam int LAT  = 1;
    localparam int LAT2 = 2;

    localparam logic [127:0] FIPS_IN = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_SUB_BYTES_SHIFTROWS_EN
    localparam logic [127:0] FIPS_OUT = 128'h63fcac161bee28c3c4c193f54b8233ea;
`else
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
`endif
    localparam logic [127:0] VEC_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VEC_B = 128'hffeeddccbbaa99887766554433221100;

    logic [7:0] sbox_rom [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic clk        = 1'b0;
    logic kill_n     = 1'b0;
    logic compare_en = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    aes_128_sub_bytes_ctrl_if bus1 ();
    aes_128_sub_bytes_ctrl_if bus2 ();

    logic [7:0] addra1, addrb1, doa1, dob1;
    logic [7:0] addra2, addrb2, doa2, dob2, pa2, pb2;
    logic       kill1, kill2;

    aes_128_sub_bytes_ctrl #(.SBOX_LAT(LAT)) dut1 (
        .clk(clk), .kill_n(kill_n), .bus(bus1),
        .sbox_addra(addra1), .sbox_addrb(addrb1), .sbox_kill(kill1),
        .sbox_doa(doa1), .sbox_dob(dob1)
    );

    aes_128_sub_bytes_ctrl #(.SBOX_LAT(LAT2)) dut2 (
        .clk(clk), .kill_n(kill_n), .bus(bus2),
        .sbox_addra(addra2), .sbox_addrb(addrb2), .sbox_kill(kill2),
        .sbox_doa(doa2), .sbox_dob(dob2)
    );

    // Dual-port S-box BRAM models with one and two output register stages.
    always @(posedge clk) begin
        if (kill1) begin
            doa1 <= '0;
            dob1 <= '0;
        end else begin
            doa1 <= sbox_rom[addra1];
            dob1 <= sbox_rom[addrb1];
        end
    end

    always @(posedge clk) begin
        if (kill2) begin
            pa2 <= '0; pb2 <= '0; doa2 <= '0; dob2 <= '0;
        end else begin
            pa2  <= sbox_rom[addra2];
            pb2  <= sbox_rom[addrb2];
            doa2 <= pa2;
            dob2 <= pb2;
        end
    end

    function automatic logic [7:0] byte_of(input logic [127:0] d, input int i);
        logic [127:0] t;
        t = d >> (8 * (15 - i));
        return t[7:0];
    endfunction

    function automatic logic [127:0] ref_result(input logic [127:0] d);
        logic [7:0]   sb [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) sb[i] = sbox_rom[byte_of(d, i)];
        r = '0;
        for (int i = 0; i < 16; i++) begin
`ifdef AES_SUB_BYTES_SHIFTROWS_EN
            r = (r << 8) | {120'd0, sb[4 * (((i / 4) + (i % 4)) % 4) + (i % 4)]};
`else
            r = (r << 8) | {120'd0, sb[i]};
`endif
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference: m_cnt counts cycles since acceptance (0 = idle); result appears at 9+LAT.
    int           m_cnt  = 0;
    logic [127:0] m_src  = '0;
    logic [127:0] m_pend = '0;
    logic [127:0] m_out  = '0;
    logic         m_kill = 1'b1;

    always @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            m_cnt  <= 0;
            m_out  <= '0;
            m_kill <= 1'b1;
        end else begin
            m_kill <= bus1.abort;
            if (m_cnt == 0) begin
                if (bus1.start && !bus1.abort) begin
                    m_cnt  <= 1;
                    m_src  <= bus1.data_in;
                    m_pend <= ref_result(bus1.data_in);
                end
            end else if (bus1.abort || m_cnt == 9 + LAT) begin
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 8 + LAT) m_out <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (compare_en) begin
            check_output("model_busy", {127'd0, bus1.busy}, {127'd0, (m_cnt >= 1 && m_cnt <= 8 + LAT)});
            check_output("model_done", {127'd0, bus1.done}, {127'd0, (m_cnt == 9 + LAT)});
            check_output("model_data_out", bus1.data_out, m_out);
            check_output("model_sbox_kill", {127'd0, kill1}, {127'd0, m_kill});
            if (m_cnt >= 1 && m_cnt <= 8) begin
                check_output("model_addra", {120'd0, addra1}, {120'd0, byte_of(m_src, 2 * (m_cnt - 1))});
                check_output("model_addrb", {120'd0, addrb1}, {120'd0, byte_of(m_src, 2 * (m_cnt - 1) + 1)});
            end
        end
    end

    task automatic apply_stimulus(input logic s, input logic a, input logic [127:0] d);
        @(posedge clk); #1;
        bus1.start   = s;
        bus1.abort   = a;
        bus1.data_in = d;
    endtask

    // Leaves the caller inside the done cycle; lat counts edges from the one that sampled start.
    task automatic run_op(input logic [127:0] d, output int lat);
        apply_stimulus(1'b1, 1'b0, d);
        apply_stimulus(1'b0, 1'b0, d);
        lat = 1;
        while (bus1.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        int busy_cycles;
        int done_count;
        logic [127:0] prev;

        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.data_in = '0;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.data_in = '0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", {127'd0, bus1.busy}, 128'd0);
        check_output("reset_done", {127'd0, bus1.done}, 128'd0);
        check_output("reset_data_out", bus1.data_out, 128'd0);
        check_output("reset_sbox_kill", {127'd0, kill1}, 128'd1);
        check_output("reset_addra", {120'd0, addra1}, 128'd0);
        kill_n     = 1'b1;
        compare_en = 1'b1;

        run_op(FIPS_IN, lat);
        check_output("fips_latency", 128'(lat), 128'd10);
        check_output("fips_data", bus1.data_out, FIPS_OUT);

        run_op('0, lat);
        check_output("zeros_latency", 128'(lat), 128'd10);
        check_output("zeros_data", bus1.data_out, {16{8'h63}});
        run_op('1, lat);
        check_output("ones_latency", 128'(lat), 128'd10);
        check_output("ones_data", bus1.data_out, {16{8'h16}});

        apply_stimulus(1'b1, 1'b0, VEC_A);
        apply_stimulus(1'b0, 1'b0, VEC_A);
        n = 0;
        busy_cycles = 0;
        while (bus1.done !== 1'b1 && n < 40) begin
            if (bus1.busy === 1'b1) busy_cycles++;
            n++;
            apply_stimulus((n == 3 || n == 6), 1'b0, (n == 3 || n == 6) ? VEC_B : VEC_A);
        end
        check_output("ignored_busy_cycles", 128'(busy_cycles), 128'd9);
        check_output("ignored_data", bus1.data_out, ref_result(VEC_A));
        done_count = 0;
        repeat (12) begin
            apply_stimulus(1'b0, 1'b0, VEC_A);
            if (bus1.done === 1'b1) done_count++;
        end
        check_output("ignored_extra_done", 128'(done_count), 128'd0);

        apply_stimulus(1'b1, 1'b1, VEC_B);
        apply_stimulus(1'b0, 1'b0, VEC_B);
        check_output("abort_wins_busy", {127'd0, bus1.busy}, 128'd0);

        prev = bus1.data_out;
        apply_stimulus(1'b1, 1'b0, FIPS_IN);
        repeat (4) apply_stimulus(1'b0, 1'b0, FIPS_IN);
        apply_stimulus(1'b0, 1'b1, FIPS_IN);
        apply_stimulus(1'b0, 1'b0, FIPS_IN);
        check_output("abort_busy", {127'd0, bus1.busy}, 128'd0);
        check_output("abort_kill", {127'd0, kill1}, 128'd1);
        apply_stimulus(1'b0, 1'b0, FIPS_IN);
        check_output("abort_kill_release", {127'd0, kill1}, 128'd0);
        done_count = 0;
        repeat (15) begin
            apply_stimulus(1'b0, 1'b0, FIPS_IN);
            if (bus1.done === 1'b1) done_count++;
        end
        check_output("abort_no_done", 128'(done_count), 128'd0);
        check_output("abort_data_hold", bus1.data_out, prev);
        run_op(FIPS_IN, lat);
        check_output("after_abort_latency", 128'(lat), 128'd10);
        check_output("after_abort_data", bus1.data_out, FIPS_OUT);

        apply_stimulus(1'b1, 1'b0, VEC_B);
        repeat (9) apply_stimulus(1'b0, 1'b0, VEC_B);
        #1 kill_n = 1'b0;
        #1;
        check_output("kill_data_out", bus1.data_out, 128'd0);
        check_output("kill_busy", {127'd0, bus1.busy}, 128'd0);
        check_output("kill_done", {127'd0, bus1.done}, 128'd0);
        check_output("kill_sbox_kill", {127'd0, kill1}, 128'd1);
        repeat (2) @(posedge clk);
        #1 kill_n = 1'b1;
        done_count = 0;
        repeat (12) begin
            apply_stimulus(1'b0, 1'b0, VEC_B);
            if (bus1.done === 1'b1) done_count++;
        end
        check_output("kill_no_done", 128'(done_count), 128'd0);
        run_op(VEC_A, lat);
        check_output("after_kill_latency", 128'(lat), 128'd10);
        check_output("after_kill_data", bus1.data_out, ref_result(VEC_A));

        @(posedge clk); #1;
        bus2.start   = 1'b1;
        bus2.data_in = FIPS_IN;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        lat = 1;
        while (bus2.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_output("lat2_latency", 128'(lat), 128'd11);
        check_output("lat2_data", bus2.data_out, FIPS_OUT);

        repeat (2) @(posedge clk);
        compare_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aes_128_sub_bytes_ctrl.md
Name: aes_128_sub_bytes_ctrl

Overview:
Initiator side of the dual-port S-box BRAM interface. Accepts one 128-bit AES state and issues two S-box lookups per cycle (ports A and B) over 8 cycles. Collects the registered S-box outputs and returns the SubBytes result with a done pulse. Sits between the round datapath and the 4-BRAM S-box bank in the 3-cycle-round encryption core.

Parameters:
SBOX_LAT, 1, S-box read latency in cycles from address to data; legal values 1 or 2.

Ports:
clk  input  1  single clock for the block and the attached S-box (both S-box clocks tied to it)
kill_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
abort  input  1  synchronous abort; returns the block to IDLE
data_in  input  128  state; byte i = data_in[127-8i -: 8]
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; data_out valid
data_out  output  128  SubBytes result, same byte order as data_in; held until the next done
sbox_addra  output  8  port A address
sbox_addrb  output  8  port B address
sbox_kill  output  1  drives the S-box kill input
sbox_doa  input  8  port A read data
sbox_dob  input  8  port B read data

Behaviour:
- Reset (kill_n=0, asynchronous): FSM=IDLE; busy=0, done=0, data_out=0, sbox_addra=0, sbox_addrb=0, sbox_kill=1 while reset is asserted.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1: latch data_in, set issue counter to 0, go to ISSUE. start=0: stay.
- ISSUE lasts 8 cycles, counter k=0..7. sbox_addra = byte 2k and sbox_addrb = byte 2k+1, taken from the latched state. After k=7, go to DRAIN.
- Capture pipeline: a SBOX_LAT-deep valid/index shift register tracks each issue. The capture for index k happens SBOX_LAT cycles after issue k: sbox_doa goes to result byte 2k and sbox_dob to result byte 2k+1.
- DRAIN lasts SBOX_LAT cycles, until the last capture. Then go to DONE.
- DONE lasts 1 cycle: done=1, data_out=result, busy=0. Next state is IDLE.
- Latency: done is high exactly 9+SBOX_LAT cycles after the edge that samples start (10 cycles with the default).
- Throughput: one state per 10+SBOX_LAT cycles. start is also accepted in the cycle after DONE.
- Addresses in IDLE, DRAIN and DONE are held at their last value. S-box write enables are tied low at the top level and are not driven by this block.
- start while busy: ignored, with no effect on the operation in flight.
- abort (any state other than IDLE): next cycle FSM=IDLE, busy=0, no done, data_out unchanged, sbox_kill=1 for one cycle. abort in IDLE: no effect beyond the sbox_kill pulse.
- abort and start in the same IDLE cycle: abort wins; start is not accepted.
- Reset mid-operation: immediate return to IDLE, data_out cleared, no done.
- sbox_kill=0 in all other cycles.

Optional Feature:
AES_SUB_BYTES_SHIFTROWS_EN
- Defined: data_out applies AES ShiftRows after SubBytes. Using column-major indexing (byte 4c+r = row r, column c), out[4c+r] = sub[4((c+r) mod 4)+r]. This is a pure remap at the output register; latency is unchanged.
- Undefined: data_out is SubBytes only.

Decomposition:
- Shared package aes_128_pkg holds:
  - the FSM state typedef (IDLE/ISSUE/DRAIN/DONE)
  - constants for byte count (16) and lookups per cycle (2)
  - a byte-extract function
  - the ShiftRows index function, reused by the cipher round
- One sub-module: aes_128_sbox_capture, the SBOX_LAT-deep valid/index pipeline plus the result byte register file.

Test Plan:
- FIPS-197 vector, SBOX_LAT=1, data_in=00112233445566778899aabbccddeeff, start for 1 cycle -> done exactly 10 cycles later, data_out=638293c31bfc33f5c4eeacea4bc12816. With AES_SUB_BYTES_SHIFTROWS_EN -> 63fcac161bee28c3c4c193f54b8233ea.
- data_in all zeros, then all ones, back-to-back (second start in the cycle after done) -> 6363…63 then 1616…16, no lost request.
- start pulsed at cycles 3 and 6 after the first accepted start -> ignored; single done with the first state's result; busy high for 9 cycles.
- abort asserted in ISSUE at k=4 -> no done, busy low next cycle, sbox_kill high for 1 cycle. A new start then completes correctly.
- kill_n low during DRAIN -> outputs reset immediately with no done. After release, a fresh start gives the correct result.
- SBOX_LAT=2 with the FIPS-197 vector -> done 11 cycles after start, same data_out.
